// File: rtl/convergence_check_controller_if.sv
// Handshake between the convergence check controller and the convergence check block.
interface convergence_check_controller_if;
    logic [2:0] cent_num;
    logic       convergence_reg_en;
    logic       convergence_regs_reset;
    logic       converge_res_available;
    logic       has_converged;

    modport master (
        output cent_num, convergence_reg_en, convergence_regs_reset,
        input  converge_res_available, has_converged
    );

    modport slave (
        input  cent_num, convergence_reg_en, convergence_regs_reset,
        output converge_res_available, has_converged
    );
endinterface

// File: rtl/convergence_check_controller.sv
// Sequences one k-means convergence check per start pulse: feeds each centroid index,
// waits for the verdict, clears the check block and decides whether the run is over.
module convergence_check_controller #(
    parameter int centroid_num = 8,
    parameter int iter_width   = 8,
    parameter int wait_limit   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  new_run,
    input  logic                  start,
    input  logic [iter_width-1:0] max_iter,
    convergence_check_controller_if.master cc,
    output logic                  busy,
    output logic                  iter_done,
    output logic                  kmeans_done,
    output logic                  converged,
    output logic                  timeout_err,
    output logic [iter_width-1:0] iter_count
);

    localparam int wait_width = $clog2(wait_limit) + 1;
    localparam logic [2:0] last_cent = 3'(centroid_num - 1);
    localparam logic [wait_width-1:0] last_wait = wait_width'(wait_limit - 1);

    typedef enum logic [2:0] {IDLE, FEED, WAIT, CLEAR, DONE} state_t;

    state_t                  state;
    logic [wait_width-1:0]   wait_cnt;
    logic                    cap_conv;
    logic [iter_width-1:0]   iter_inc;
    logic                    run_over;

    always_comb begin
        iter_inc = (iter_count == '1) ? iter_count : iter_count + iter_width'(1);
    end

    // iter_count has already been bumped in WAIT, so the limit compares against it directly;
    // timeout_err can only be set for the iteration in flight, since leaving DONE requires new_run.
    always_comb begin
        run_over = cap_conv || timeout_err || ((max_iter != '0) && (iter_count == max_iter));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            cc.cent_num               <= '0;
            cc.convergence_reg_en     <= 1'b0;
            cc.convergence_regs_reset <= 1'b1;
            busy                      <= 1'b0;
            iter_done                 <= 1'b0;
            kmeans_done               <= 1'b0;
            converged                 <= 1'b0;
            timeout_err               <= 1'b0;
            iter_count                <= '0;
            wait_cnt                  <= '0;
            cap_conv                  <= 1'b0;
        end else begin
            iter_done   <= 1'b0;
            kmeans_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_run) begin
                        iter_count  <= '0;
                        converged   <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                    if (start) begin
                        state                 <= FEED;
                        cc.cent_num           <= '0;
                        cc.convergence_reg_en <= 1'b1;
                        busy                  <= 1'b1;
                    end
                end
                FEED: begin
                    if (cc.cent_num == last_cent) begin
                        state                 <= WAIT;
                        cc.convergence_reg_en <= 1'b0;
                        wait_cnt              <= '0;
                    end else begin
                        cc.cent_num <= cc.cent_num + 3'd1;
                    end
                end
                WAIT: begin
                    if (cc.converge_res_available) begin
                        cap_conv                  <= cc.has_converged;
                        iter_count                <= iter_inc;
                        state                     <= CLEAR;
                        cc.convergence_regs_reset <= 1'b0;
                    end else if (wait_cnt == last_wait) begin
                        timeout_err               <= 1'b1;
                        cap_conv                  <= 1'b0;
                        state                     <= CLEAR;
                        cc.convergence_regs_reset <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + wait_width'(1);
                    end
                end
                CLEAR: begin
                    cc.convergence_regs_reset <= 1'b1;
                    busy                      <= 1'b0;
                    if (run_over) begin
                        state       <= DONE;
                        kmeans_done <= 1'b1;
                        converged   <= cap_conv;
                    end else begin
                        state     <= IDLE;
                        iter_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (new_run) begin
                        state       <= IDLE;
                        iter_count  <= '0;
                        converged   <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                default: begin
                    state                     <= IDLE;
                    busy                      <= 1'b0;
                    cc.convergence_reg_en     <= 1'b0;
                    cc.convergence_regs_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convergence_check_controller.sv
// Directed bench for convergence_check_controller: iteration sequencing, run termination,
// timeout, reset abort and ignored control pulses.
module tb_convergence_check_controller;

    localparam int WL = 16;

    logic       clk;
    logic       rst_n;
    logic       new_run;
    logic       start;
    logic [7:0] max_iter;
    logic       busy;
    logic       iter_done;
    logic       kmeans_done;
    logic       converged;
    logic       timeout_err;
    logic [7:0] iter_count;

    int n_checks;
    int n_errors;

    convergence_check_controller_if ccif ();

    convergence_check_controller #(
        .centroid_num(8),
        .iter_width  (8),
        .wait_limit  (WL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_run    (new_run),
        .start      (start),
        .max_iter   (max_iter),
        .cc         (ccif.master),
        .busy       (busy),
        .iter_done  (iter_done),
        .kmeans_done(kmeans_done),
        .converged  (converged),
        .timeout_err(timeout_err),
        .iter_count (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full iteration from start to the end-of-iteration pulse.
    // avail_delay >= WL means the result never arrives (timeout path).
    task automatic run_iter(input logic conv, input int unsigned avail_delay,
                            input logic exp_done, input logic [7:0] exp_count,
                            input logic noise);
        logic tmo;
        tmo = (avail_delay >= WL);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("feed_en", ccif.convergence_reg_en, 1);
            check("feed_cent", ccif.cent_num, i);
            check("feed_busy", busy, 1);
            start = (noise && i == 3);
            tick;
            start = 1'b0;
        end
        check("wait_en", ccif.convergence_reg_en, 0);
        check("wait_cent", ccif.cent_num, 7);
        if (!tmo) begin
            for (int unsigned j = 0; j < avail_delay; j++) begin
                new_run = noise;
                start   = noise;
                tick;
                new_run = 1'b0;
                start   = 1'b0;
            end
            ccif.converge_res_available = 1'b1;
            ccif.has_converged          = conv;
            tick;
            ccif.converge_res_available = 1'b0;
            ccif.has_converged          = 1'b0;
        end else begin
            repeat (WL - 1) tick;
            check("tmo_still_wait", ccif.convergence_regs_reset, 1);
            check("tmo_not_yet", timeout_err, 0);
            tick;
        end
        check("clear_low", ccif.convergence_regs_reset, 0);
        check("clear_busy", busy, 1);
        check("clear_tmo", timeout_err, tmo);
        tick;
        check("clear_high", ccif.convergence_regs_reset, 1);
        check("iter_done", iter_done, !exp_done);
        check("kmeans_done", kmeans_done, exp_done);
        check("iter_count", iter_count, exp_count);
        check("converged", converged, exp_done & conv & !tmo);
        check("post_busy", busy, 0);
        tick;
        check("iter_done_pulse", iter_done, 0);
        check("kmeans_done_pulse", kmeans_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        new_run  = 1'b0;
        start    = 1'b0;
        max_iter = 8'd5;
        ccif.converge_res_available = 1'b0;
        ccif.has_converged          = 1'b0;
        #12;
        check("rst_cent", ccif.cent_num, 0);
        check("rst_en", ccif.convergence_reg_en, 0);
        check("rst_regs_reset", ccif.convergence_regs_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {iter_done, kmeans_done}, 0);
        check("rst_sticky", {converged, timeout_err}, 0);
        check("rst_count", iter_count, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // Basic iterations with max_iter=5; second one injects ignored start/new_run.
        new_run = 1'b1;
        tick;
        new_run = 1'b0;
        check("newrun_count", iter_count, 0);
        run_iter(1'b0, 2, 1'b0, 8'd1, 1'b0);
        run_iter(1'b0, 2, 1'b0, 8'd2, 1'b1);
        run_iter(1'b1, 0, 1'b1, 8'd3, 1'b0);

        // DONE holds and ignores start.
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check("done_ignore_start_en", ccif.convergence_reg_en, 0);
        check("done_ignore_start_busy", busy, 0);
        check("done_hold_conv", converged, 1);
        check("done_hold_count", iter_count, 3);

        // Iteration limit of 2.
        max_iter = 8'd2;
        new_run  = 1'b1;
        tick;
        new_run  = 1'b0;
        check("limit_clear_count", iter_count, 0);
        check("limit_clear_conv", converged, 0);
        run_iter(1'b0, 1, 1'b0, 8'd1, 1'b0);
        run_iter(1'b0, 1, 1'b1, 8'd2, 1'b0);

        // Timeout with unlimited iterations.
        max_iter = 8'd0;
        new_run  = 1'b1;
        tick;
        new_run  = 1'b0;
        run_iter(1'b0, WL, 1'b1, 8'd0, 1'b0);
        check("tmo_sticky", timeout_err, 1);

        // new_run together with start: clear applies and the iteration begins.
        new_run = 1'b1;
        tick;
        new_run = 1'b0;
        check("tmo_cleared", timeout_err, 0);
        new_run = 1'b1;
        start   = 1'b1;
        tick;
        new_run = 1'b0;
        start   = 1'b0;
        check("combo_en", ccif.convergence_reg_en, 1);
        check("combo_cent", ccif.cent_num, 0);
        repeat (4) tick;
        check("pre_rst_cent", ccif.cent_num, 4);
        rst_n = 1'b0;
        #1;
        check("async_rst_en", ccif.convergence_reg_en, 0);
        check("async_rst_cent", ccif.cent_num, 0);
        check("async_rst_busy", busy, 0);
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        check("post_rst_idle_en", ccif.convergence_reg_en, 0);
        check("post_rst_idle_busy", busy, 0);
        run_iter(1'b0, 3, 1'b0, 8'd1, 1'b0);

        // Result strobe outside WAIT has no effect.
        ccif.converge_res_available = 1'b1;
        ccif.has_converged          = 1'b1;
        tick;
        tick;
        ccif.converge_res_available = 1'b0;
        ccif.has_converged          = 1'b0;
        check("stray_avail_busy", busy, 0);
        check("stray_avail_conv", converged, 0);
        check("stray_avail_count", iter_count, 1);
        check("stray_avail_pulse", {iter_done, kmeans_done}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
